// File: rtl/uart_pkg.sv
// Shared UART definitions: state codes, default timing, parity helper.
// Used by uart_tx (optional parity via UART_TX_PARITY_EN) and the receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  // Even parity bit: makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle.
// Part of uart_tx (UART_TX_PARITY_EN does not affect this block).
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_done;
  logic                 clr;
  logic                 line;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign tx_ready = (state == IDLE);
  assign busy = !tx_ready;
  // Counter held at zero while idle so each frame starts a fresh period.
  assign clr = tx_ready | bit_done;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bit_done(bit_done)
  );

  always_comb begin
    line = 1'b1;
    case (state)
      IDLE:   line = 1'b1;
      START:  line = 1'b0;
      DATA:   line = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: line = parity;
`endif
      STOP:   line = 1'b1;
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      tx <= line;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity    <= even_parity(8'(tx_data));
`endif
            state     <= START;
          end
        end
        START: begin
          if (bit_done) state <= DATA;
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) state <= STOP;
        end
`endif
        STOP: begin
          if (bit_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (4 clk/8 bits, 2 clk/5 bits).
// Honours UART_TX_PARITY_EN when defined for the compile.
module tb_uart_tx;

  localparam int C1 = 4;
  localparam int D1 = 8;
  localparam int C2 = 2;
  localparam int D2 = 5;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data1;
  logic       valid1;
  logic       ready1;
  logic       tx1;
  logic       busy1;
  logic [4:0] data2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         act[2];
  int         pos[2];
  int         idle_cnt[2];
  int         last_gap[2];
  int         done[2];
  logic [7:0] cur[2];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C1), .DATA_BITS(D1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.CLKS_PER_BIT(C2), .DATA_BITS(D2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .tx(tx2), .busy(busy2)
  );

  function automatic logic exp_bit(input logic [7:0] b, input int d,
                                   input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= d) return b[idx-1];
    if (PB == 1 && idx == d + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Line monitor: pops the expected byte at each start bit, then checks
  // every cycle of every bit of the frame.
  task automatic mon_step(input int id, input logic txv);
    int c;
    int d;
    int n;
    logic e;
    c = (id == 0) ? C1 : C2;
    d = (id == 0) ? D1 : D2;
    n = (d + 2 + PB) * c;
    if (rst) begin
      act[id] = 0;
      idle_cnt[id] = 0;
      return;
    end
    if (act[id] == 0) begin
      if (txv) begin
        idle_cnt[id]++;
        return;
      end
      checks++;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_frame dut%0d", id);
        cur[id] = 8'h00;
      end else if (id == 0) begin
        cur[id] = q0.pop_front();
      end else begin
        cur[id] = q1.pop_front();
      end
      act[id] = 1;
      pos[id] = 0;
      last_gap[id] = idle_cnt[id];
      idle_cnt[id] = 0;
    end
    e = exp_bit(cur[id], d, pos[id] / c);
    checks++;
    if (txv !== e) begin
      errors++;
      $display("FAIL tx_bit dut%0d byte %h bit %0d cyc %0d: got %b want %b",
               id, cur[id], pos[id] / c, pos[id] % c, txv, e);
    end
    pos[id]++;
    if (pos[id] == n) begin
      act[id] = 0;
      done[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, tx1);
    mon_step(1, tx2);
  end

  function automatic logic rdy(input int id);
    return (id == 0) ? ready1 : ready2;
  endfunction

  task automatic wait_ready(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy(id) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got 0 want 1", id);
    end
  endtask

  task automatic wait_done(input int id, input int target);
    int n;
    n = 0;
    while (done[id] < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("frame_done_dut%0d", id), done[id], target);
  endtask

  // Issue one byte and return how many cycles tx_ready stayed low.
  task automatic send(input int id, input logic [7:0] b, output int n);
    wait_ready(id);
    if (id == 0) begin
      data1 = b;
      valid1 = 1'b1;
      q0.push_back(b);
    end else begin
      data2 = b[4:0];
      valid2 = 1'b1;
      q1.push_back(b);
    end
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      if (!rdy(id)) n++;
    end while (!rdy(id) && n < 500);
  endtask

  initial begin
    int n;
    valid1 = 1'b0;
    valid2 = 1'b0;
    data1 = 8'h00;
    data2 = 5'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx1, 1);
    chk("rst_ready", ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_tx2", tx2, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", tx1, 1);
    chk("post_rst_ready", ready1, 1);
    chk("post_rst_busy", busy1, 0);

    send(0, 8'hA5, n);
    chk("ready_low_a5", n, (10 + PB) * C1);
    wait_done(0, 1);

    send(0, 8'h07, n);
    chk("ready_low_07", n, (10 + PB) * C1);
    wait_done(0, 2);

    // Back-to-back with tx_valid held high and data changing mid-frame.
    wait_ready(0);
    data1 = 8'h00;
    valid1 = 1'b1;
    q0.push_back(8'h00);
    @(posedge clk);
    #1;
    data1 = 8'hFF;
    q0.push_back(8'hFF);
    wait_ready(0);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data1 = 8'h12;
    wait_done(0, 4);
    chk("b2b_gap", last_gap[0], 1);

    // Reset during the third data bit of 0x55.
    wait_ready(0);
    data1 = 8'h55;
    valid1 = 1'b1;
    q0.push_back(8'h55);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx1, 1);
    chk("mid_rst_ready", ready1, 1);
    chk("mid_rst_busy", busy1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx1 !== 1'b1) n++;
    end
    chk("idle_after_rst_low_cycles", n, 0);
    chk("aborted_frame_popped", q0.size(), 0);
    send(0, 8'h3C, n);
    chk("ready_low_3c", n, (10 + PB) * C1);
    wait_done(0, 5);

    send(1, 8'h13, n);
    chk("ready_low_dut2", n, (D2 + 2 + PB) * C2);
    wait_done(1, 1);

    repeat (4) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the lab board's UART link, the sending end paired with the register-sampled receive path. Accepts one byte over a valid/ready handshake, then shifts it out on a single line as start bit, data bits LSB first, and stop bit, each held for a fixed number of clock cycles. It sits between user logic that produces bytes and the board's TX pin. The line idles high.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal minimum 2.
- DATA_BITS, default 8: data bits per frame; legal range 5–8.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_BITS  byte to send; sampled only on an accepted handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmitter can accept a byte; high only in IDLE.
- tx  output  1  serial line; registered output; idles high.
- busy  output  1  a frame is in progress; equals !tx_ready.

## Operation
- Reset values: tx=1, tx_ready=1, busy=0, state=IDLE, bit counter=0, baud counter=0. These take effect immediately on rst assertion and hold until rst deasserts.
- States:
  - IDLE: tx=1. On tx_valid && tx_ready, latch tx_data into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit. After each bit, shift right and increment the bit counter. After DATA_BITS bits, go to PARITY if enabled, otherwise STOP.
  - PARITY (only with the macro): tx = even parity of the latched byte for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Clears on every state transition.
  - A bit ends when the counter equals CLKS_PER_BIT-1.
- Input data: tx_data and tx_valid are ignored outside IDLE. Changing tx_data after acceptance does not affect the frame in flight.
- tx_valid held high continuously: a new frame is accepted on every IDLE cycle.
- Reset mid-frame: the frame is aborted, tx returns high immediately, and no partial frame resumes after reset.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter and $clog2(DATA_BITS+1) for the bit counter. No wrap-around beyond the terminal counts.

## Timing
- Handshake accepted at rising edge T. tx falls to 0 at edge T+1, which is the start of the start bit.
- Frame length, in cycles, from the T+1 edge to the return to IDLE:
  - (DATA_BITS+2)·CLKS_PER_BIT without parity.
  - (DATA_BITS+3)·CLKS_PER_BIT with parity.
- tx_ready rises on the same edge where STOP ends. The earliest next acceptance is at that edge plus 1, which gives at least 1 idle-high cycle between frames.
- tx changes only on clock edges, or on rst assertion.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: adds the PARITY state and one even-parity bit between the last data bit and the stop bit.
  - Undefined: no parity state, no parity logic, and frames are 8N1 (for DATA_BITS=8).

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the defaults DEFAULT_CLKS_PER_BIT = 868 and DEFAULT_DATA_BITS = 8;
  - a function for even parity. The future receiver will reuse this package.
- Sub-module uart_baud_cnt: parameterised by CLKS_PER_BIT, with inputs clk, rst, and clr, and output bit_done. It is the only natural split; the FSM and shift register stay in uart_tx.

## Test plan
Benches use CLKS_PER_BIT=4 and DATA_BITS=8 unless noted.
- Reset: assert rst mid-idle, then release. tx=1, tx_ready=1, and busy=0 while rst is asserted and after release.
- Send 0xA5: tx reads 0 | 1,0,1,0,0,1,0,1 | 1, each level held exactly 4 cycles. tx_ready=0 for 40 cycles, then returns to 1.
- With UART_TX_PARITY_EN:
  - Send 0xA5: parity bit 0 is inserted before stop; frame is 44 cycles.
  - Send 0x07: parity bit is 1.
- Back-to-back: tx_valid held high with 0x00 then 0xFF. Both frames are correct, with exactly 1 idle-high cycle between the first stop bit and the second start bit. tx_data changing mid-frame has no effect.
- Reset mid-frame: assert rst during the 3rd data bit of 0x55. tx goes 1 asynchronously. After release, tx stays idle-high until a new handshake, and the next frame (0x3C) is correct.
- Parameter sweep: CLKS_PER_BIT=2 and DATA_BITS=5, send 0x13. Bits 1,1,0,0,1 are sent LSB first, each held 2 cycles; frame is 14 cycles.
